exc_seq_ctrl: RTL and testbench

//  Exception/interrupt sequencer for the 5-stage MIPS pipeline. Consumes the coprocessor-0 exception request
//  and the M-stage ERET indication and sequences pipeline flush, PC redirect (handler entry or EPC), EXL clear
//  and a post-ERET interrupt guard window that prevents livelock. Sits beside the hazard unit and drives the

---
 rtl/exc_seq_ctrl_pkg.sv | 24 ++
 rtl/exc_seq_ctrl_if.sv | 30 +++
 rtl/exc_seq_ctrl.sv | 101 ++++++++++
 tb/tb_exc_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/exc_seq_ctrl_pkg.sv
// Shared definitions for the exception/interrupt sequencer: state encoding,
// default handler vector and flush-vector bit positions.
package exc_seq_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_EXC_FLUSH  = 2'd1;
  localparam state_t ST_ERET_FLUSH = 2'd2;
  localparam state_t ST_GUARD      = 2'd3;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

  localparam int FL_D = 0;
  localparam int FL_E = 1;
  localparam int FL_M = 2;
  localparam int FL_W = 3;

  // ERET returns to a word-aligned EPC; low bits are forced clear.
  function automatic logic [31:0] eret_target(input logic [31:0] epc);
    return epc & ~32'h3;
  endfunction

endpackage

// File: rtl/exc_seq_ctrl_if.sv
// Request/response bundle between CP0 + pipeline control (master) and the
// exception sequencer (slave).
interface exc_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             exc_req;
  logic             exc_is_int;
  logic             eret_m;
  logic [31:0]      epc;
  logic             md_busy;
  logic             stall_in;
  logic [3:0]       flush;
  logic             pc_redirect;
  logic [31:0]      pc_target;
  logic             cp0_clear;
  logic             md_cancel;
  logic             stall_out;
  logic             busy;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output exc_req, exc_is_int, eret_m, epc, md_busy, stall_in,
    input  flush, pc_redirect, pc_target, cp0_clear, md_cancel, stall_out, busy, exc_count
  );

  modport slave (
    input  exc_req, exc_is_int, eret_m, epc, md_busy, stall_in,
    output flush, pc_redirect, pc_target, cp0_clear, md_cancel, stall_out, busy, exc_count
  );
endinterface

// File: rtl/exc_seq_ctrl.sv
// Exception/interrupt sequencer: flushes the pipeline and redirects the PC on
// exceptions and ERET, then holds off interrupts for a short post-ERET window.
module exc_seq_ctrl
  import exc_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int          GUARD_CYCLES = 3,
  parameter int          CNT_W        = 16
) (
  input logic           clk,
  input logic           reset,
  exc_seq_ctrl_if.slave bus
);

  localparam int            GW         = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYCLES);

  state_t           state, state_nx;
  logic [GW-1:0]    guard_cnt;
  logic [CNT_W-1:0] cnt_q;
  logic             guard_active;
  logic             accept_exc;
  logic             hold;

  // Guard only masks interrupts; synchronous exceptions always get through.
  assign guard_active = (guard_cnt != '0);
  assign accept_exc   = bus.exc_req && !(bus.exc_is_int && guard_active);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept_exc)      state_nx = ST_EXC_FLUSH;
        else if (bus.eret_m) state_nx = ST_ERET_FLUSH;
      end
      ST_EXC_FLUSH:  state_nx = ST_IDLE;
      ST_ERET_FLUSH: state_nx = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
      ST_GUARD: begin
        if (accept_exc)                  state_nx = ST_EXC_FLUSH;
        else if (guard_cnt <= GW'(1))    state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.flush       = '0;
    bus.pc_redirect = 1'b0;
    bus.pc_target   = '0;
    bus.cp0_clear   = 1'b0;
    bus.md_cancel   = 1'b0;
    hold            = 1'b0;
    case (state)
      ST_EXC_FLUSH: begin
        bus.flush       = 4'b1111;
        bus.pc_redirect = 1'b1;
        bus.pc_target   = HANDLER_ADDR;
        bus.md_cancel   = bus.md_busy;
        hold            = 1'b1;
      end
      ST_ERET_FLUSH: begin
        // ERET itself sits in M, so W retires normally.
        bus.flush[FL_D] = 1'b1;
        bus.flush[FL_E] = 1'b1;
        bus.flush[FL_M] = 1'b1;
        bus.pc_redirect = 1'b1;
        bus.pc_target   = eret_target(bus.epc);
        bus.cp0_clear   = 1'b1;
        hold            = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guard_cnt <= '0;
    end else begin
      case (state)
        ST_ERET_FLUSH: guard_cnt <= GUARD_INIT;
        ST_GUARD:      guard_cnt <= accept_exc ? '0 : guard_cnt - GW'(1);
        default:       guard_cnt <= guard_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   cnt_q <= '0;
    else if (state == ST_EXC_FLUSH) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.stall_out = bus.stall_in | hold;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.exc_count = cnt_q;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Bench for exc_seq_ctrl: directed cycle table, counter wrap, then random
// stimulus checked against a rule-level reference model.
module tb_exc_seq_ctrl;

  localparam int          CW = 4;
  localparam int          GC = 3;
  localparam logic [31:0] HA = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exc_seq_ctrl_if #(.CNT_W(CW)) bus ();

  exc_seq_ctrl #(.HANDLER_ADDR(HA), .GUARD_CYCLES(GC), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        rst, req, isint, eret;
    logic [31:0] epc;
    logic        mdb, stl;
  } vin_t;

  typedef struct packed {
    logic [3:0]    flush;
    logic          rd;
    logic [31:0]   tgt;
    logic          clr, mdc, so, bsy;
    logic [CW-1:0] cnt;
  } vout_t;

  typedef struct packed {
    logic  chk;
    vin_t  i;
    vout_t o;
  } row_t;

  int total = 0;
  int bad   = 0;

  // Reference model: the action happening this cycle, guard cycles left, count.
  int m_act   = 0;  // 0 none, 1 exception redirect, 2 eret redirect
  int m_guard = 0;
  int m_cnt   = 0;

  function automatic vout_t model_out(input vin_t v);
    vout_t o;
    o     = '0;
    o.cnt = CW'(m_cnt);
    o.so  = v.stl;
    o.bsy = (m_act != 0) || (m_guard > 0);
    if (m_act == 1) begin
      o.flush = 4'hF; o.rd = 1'b1; o.tgt = HA; o.mdc = v.mdb; o.so = 1'b1;
    end else if (m_act == 2) begin
      o.flush = 4'h7; o.rd = 1'b1; o.tgt = v.epc & ~32'h3; o.clr = 1'b1; o.so = 1'b1;
    end
    return o;
  endfunction

  task automatic model_adv(input vin_t v);
    if (v.rst) begin
      m_act = 0; m_guard = 0; m_cnt = 0;
    end else if (m_act == 1) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_act = 0;
    end else if (m_act == 2) begin
      m_act = 0;
      m_guard = GC;
    end else if (v.req && (!v.isint || m_guard == 0)) begin
      m_act = 1; m_guard = 0;
    end else if (m_guard == 0 && v.eret) begin
      m_act = 2;
    end else if (m_guard > 0) begin
      m_guard = m_guard - 1;
    end
  endtask

  task automatic step(input vin_t v, input bit chk, input vout_t exp_o, input bit use_model,
                      input string nm);
    vout_t act, e;
    reset          = v.rst;
    bus.exc_req    = v.req;
    bus.exc_is_int = v.isint;
    bus.eret_m     = v.eret;
    bus.epc        = v.epc;
    bus.md_busy    = v.mdb;
    bus.stall_in   = v.stl;
    #1;
    act = {bus.flush, bus.pc_redirect, bus.pc_target, bus.cp0_clear, bus.md_cancel,
           bus.stall_out, bus.busy, bus.exc_count};
    e = use_model ? model_out(v) : exp_o;
    if (chk) begin
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got fl=%h rd=%b tgt=%h clr=%b mdc=%b so=%b bsy=%b cnt=%0d want fl=%h rd=%b tgt=%h clr=%b mdc=%b so=%b bsy=%b cnt=%0d",
                 nm, act.flush, act.rd, act.tgt, act.clr, act.mdc, act.so, act.bsy, act.cnt,
                 e.flush, e.rd, e.tgt, e.clr, e.mdc, e.so, e.bsy, e.cnt);
      end
    end
    @(posedge clk);
    model_adv(v);
    @(negedge clk);
  endtask

  function automatic row_t R(input bit chk, input bit rst, input bit req, input bit isint,
                             input bit eret, input logic [31:0] epc, input bit mdb, input bit stl,
                             input logic [3:0] fl, input bit rd, input logic [31:0] tgt,
                             input bit clr, input bit mdc, input bit so, input bit bsy, input int cnt);
    row_t r;
    r.chk = chk;
    r.i   = '{rst, req, isint, eret, epc, mdb, stl};
    r.o   = '{fl, rd, tgt, clr, mdc, so, bsy, CW'(cnt)};
    return r;
  endfunction

  row_t  tab[28];
  vin_t  vr;
  vout_t none_o;

  initial begin
    none_o = '0;
    //         chk rst req int eret epc           mdb stl   fl    rd tgt           clr mdc so bsy cnt
    tab[0]  = R(0, 1, 0, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 0);
    tab[1]  = R(1, 1, 0, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 0);
    tab[2]  = R(1, 0, 1, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 0);
    tab[3]  = R(1, 0, 0, 0, 0, 32'h0,         0, 0,   4'hF, 1, HA,           0, 0, 1, 1, 0);
    tab[4]  = R(1, 0, 0, 0, 1, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 1);
    tab[5]  = R(1, 0, 0, 0, 0, 32'h3006,      0, 0,   4'h7, 1, 32'h3004,     1, 0, 1, 1, 1);
    tab[6]  = R(1, 0, 1, 1, 0, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 1, 1);
    tab[7]  = R(1, 0, 1, 1, 0, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 1, 1);
    tab[8]  = R(1, 0, 1, 1, 0, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 1, 1);
    tab[9]  = R(1, 0, 1, 1, 0, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 1);
    tab[10] = R(1, 0, 0, 0, 0, 32'h0,         0, 0,   4'hF, 1, HA,           0, 0, 1, 1, 1);
    tab[11] = R(1, 0, 1, 0, 1, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 2);
    tab[12] = R(1, 0, 0, 0, 0, 32'h3006,      0, 0,   4'hF, 1, HA,           0, 0, 1, 1, 2);
    tab[13] = R(1, 0, 1, 0, 0, 32'h0,         1, 1,   4'h0, 0, 32'h0,        0, 0, 1, 0, 3);
    tab[14] = R(1, 0, 0, 0, 0, 32'h0,         1, 1,   4'hF, 1, HA,           0, 1, 1, 1, 3);
    tab[15] = R(1, 0, 0, 0, 0, 32'h0,         1, 1,   4'h0, 0, 32'h0,        0, 0, 1, 0, 4);
    tab[16] = R(1, 0, 1, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 4);
    tab[17] = R(1, 0, 1, 0, 0, 32'h0,         0, 0,   4'hF, 1, HA,           0, 0, 1, 1, 4);
    tab[18] = R(1, 0, 0, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 5);
    tab[19] = R(1, 0, 0, 0, 1, 32'h3006,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 5);
    tab[20] = R(1, 1, 0, 0, 0, 32'h3006,      0, 0,   4'h7, 1, 32'h3004,     1, 0, 1, 1, 5);
    tab[21] = R(1, 0, 0, 0, 1, 32'h1001,      0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 0);
    tab[22] = R(1, 0, 0, 0, 0, 32'h1001,      0, 0,   4'h7, 1, 32'h1000,     1, 0, 1, 1, 0);
    tab[23] = R(1, 0, 1, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 1, 0);
    tab[24] = R(1, 0, 1, 1, 0, 32'h0,         0, 0,   4'hF, 1, HA,           0, 0, 1, 1, 0);
    tab[25] = R(1, 0, 1, 1, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 1);
    tab[26] = R(1, 0, 0, 0, 0, 32'h0,         0, 0,   4'hF, 1, HA,           0, 0, 1, 1, 1);
    tab[27] = R(1, 0, 0, 0, 0, 32'h0,         0, 0,   4'h0, 0, 32'h0,        0, 0, 0, 0, 2);

    for (int k = 0; k < 28; k++)
      step(tab[k].i, tab[k].chk, tab[k].o, 1'b0, $sformatf("row%0d", k));

    // Counter wrap: 16 accepted exceptions bring a 4-bit count back to 0.
    vr = '0; vr.rst = 1'b1;
    step(vr, 1'b1, none_o, 1'b1, "wrap_reset");
    for (int n = 0; n < 16; n++) begin
      vr = '0; vr.req = 1'b1;
      step(vr, 1'b1, none_o, 1'b1, $sformatf("wrap_req%0d", n));
      vr = '0;
      step(vr, 1'b1, none_o, 1'b1, $sformatf("wrap_flush%0d", n));
    end
    #1;
    total++;
    if (bus.exc_count !== CW'(0)) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 0", bus.exc_count);
    end

    for (int n = 0; n < 600; n++) begin
      vr.rst   = ($urandom_range(0, 39) == 0);
      vr.req   = ($urandom_range(0, 3) == 0);
      vr.isint = $urandom_range(0, 1);
      vr.eret  = ($urandom_range(0, 2) == 0);
      vr.epc   = $urandom;
      vr.mdb   = $urandom_range(0, 1);
      vr.stl   = ($urandom_range(0, 3) == 0);
      step(vr, 1'b1, none_o, 1'b1, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
